online_adder_serial_ctrl: RTL and testbench

//  Sequencer for the radix-2 MSD-first signed-digit serial online adder. Accepts two NDIG-digit

---
 rtl/online_adder_serial_ctrl_pkg.sv | 21 ++
 rtl/online_adder_serial_ctrl_if.sv | 32 +++
 rtl/online_adder_serial_ctrl_sd_shift_reg.sv | 52 +++++
 rtl/online_adder_serial_ctrl.sv | 138 +++++++++++++
 tb/tb_online_adder_serial_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/online_adder_serial_ctrl_pkg.sv
// Shared definitions for the serial online adder sequencer.
//   state_e   : controller states (flush, idle, run, done)
//   ZeroDigit : borrow-save zero digit {p, n} driven to the adder when no operand digit is due
//   cnt_width : width of the run/flush counter
package online_adder_serial_ctrl_pkg;

   typedef enum logic [1:0] {
      StFlush,
      StIdle,
      StRun,
      StDone
   } state_e;

   localparam logic [1:0] ZeroDigit = 2'b00;

   // The counter must hold 0..NDIG+DELAY-1 with one spare code so it never wraps.
   function automatic int unsigned cnt_width(input int unsigned ndig, input int unsigned delay);
      return $clog2(ndig + delay + 1);
   endfunction

endpackage

// File: rtl/online_adder_serial_ctrl_if.sv
// Parallel operand/result handshake bundle of the serial online adder sequencer.
//   in_valid/in_ready        : operand pair handshake
//   a_p/a_n, b_p/b_n [NDIG]  : borrow-save operands, bit NDIG-1 is the MSD
//   out_valid/out_ready      : result handshake
//   sum_p/sum_n [NDIG+1]     : borrow-save result, bit NDIG is the overflow MSD
// master = operand source / result consumer, slave = the sequencer.
interface online_adder_serial_ctrl_if #(
   parameter int unsigned NDIG = 8
) ();

   logic            in_valid;
   logic            in_ready;
   logic [NDIG-1:0] a_p;
   logic [NDIG-1:0] a_n;
   logic [NDIG-1:0] b_p;
   logic [NDIG-1:0] b_n;
   logic            out_valid;
   logic            out_ready;
   logic [NDIG:0]   sum_p;
   logic [NDIG:0]   sum_n;

   modport master (
      output in_valid, a_p, a_n, b_p, b_n, out_ready,
      input  in_ready, out_valid, sum_p, sum_n
   );

   modport slave (
      input  in_valid, a_p, a_n, b_p, b_n, out_ready,
      output in_ready, out_valid, sum_p, sum_n
   );

endinterface

// File: rtl/online_adder_serial_ctrl_sd_shift_reg.sv
// Parallel-load, MSD-out borrow-save digit shifter.
//   clk, rst_n    : clock, asynchronous active-low reset
//   load          : capture din_p/din_n (wins over shift)
//   shift         : move one digit towards the MSD, zero digit enters at the LSD
//   din_p/din_n   : parallel digits, bit NDIG-1 = MSD
//   msd_p/msd_n   : current MSD, straight from the register
// Zero fill means the MSD output becomes a zero digit once all digits have left, which is
// exactly what the adder needs during the tail flush.
module online_adder_serial_ctrl_sd_shift_reg
   import online_adder_serial_ctrl_pkg::*;
#(
   parameter int unsigned NDIG = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            shift,
   input  logic [NDIG-1:0] din_p,
   input  logic [NDIG-1:0] din_n,
   output logic            msd_p,
   output logic            msd_n
);

   logic [NDIG-1:0] p_q, p_d;
   logic [NDIG-1:0] n_q, n_d;

   always_comb begin
      p_d = p_q;
      n_d = n_q;
      if (load) begin
         p_d = din_p;
         n_d = din_n;
      end else if (shift) begin
         p_d = {p_q[NDIG-2:0], ZeroDigit[1]};
         n_d = {n_q[NDIG-2:0], ZeroDigit[0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= '0;
         n_q <= '0;
      end else begin
         p_q <= p_d;
         n_q <= n_d;
      end
   end

   assign msd_p = p_q[NDIG-1];
   assign msd_n = n_q[NDIG-1];

endmodule

// File: rtl/online_adder_serial_ctrl.sv
// Sequencer for a radix-2 MSD-first signed-digit serial online adder.
//   clk, rst_n              : clock, asynchronous active-low reset
//   bus (slave)             : operand/result handshake, see online_adder_serial_ctrl_if
//   busy                    : high in flush, run and done
//   ad_d1p/ad_d1n           : adder input digit from A (registered)
//   ad_d2p/ad_d2n           : adder input digit from B (registered)
//   ad_qp/ad_qn             : adder output digit
// Operands are streamed MSD-first for NDIG cycles followed by DELAY zero digits; NDIG+1 output
// digits are collected, the first one landing in bit NDIG.
module online_adder_serial_ctrl
   import online_adder_serial_ctrl_pkg::*;
#(
   parameter int unsigned NDIG  = 8,
   parameter int unsigned DELAY = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   online_adder_serial_ctrl_if.slave bus,
   output logic                      busy,
   output logic                      ad_d1p,
   output logic                      ad_d1n,
   output logic                      ad_d2p,
   output logic                      ad_d2n,
   input  logic                      ad_qp,
   input  logic                      ad_qn
);

   localparam int unsigned CntW = cnt_width(NDIG, DELAY);
   localparam logic [CntW-1:0] FlushLast = CntW'(DELAY - 1);
   localparam logic [CntW-1:0] CapFirst  = CntW'(DELAY - 1);
   localparam logic [CntW-1:0] RunLast   = CntW'(NDIG + DELAY - 1);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [NDIG:0]   sum_p_q, sum_p_d;
   logic [NDIG:0]   sum_n_q, sum_n_d;
   logic            load;
   logic            shift;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sum_p_d = sum_p_q;
      sum_n_d = sum_n_q;
      load    = 1'b0;
      shift   = 1'b0;
      unique case (state_q)
         // Shifters are zero out of reset, so the adder sees zero digits here.
         StFlush: begin
            if (cnt_q == FlushLast) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StIdle: begin
            if (bus.in_valid) begin
               load    = 1'b1;
               sum_p_d = '0;
               sum_n_d = '0;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            shift = 1'b1;
            // The adder's first valid digit appears DELAY-1 cycles after the MSD is presented.
            if (cnt_q >= CapFirst) begin
               sum_p_d = {sum_p_q[NDIG-1:0], ad_qp};
               sum_n_d = {sum_n_q[NDIG-1:0], ad_qn};
            end
            if (cnt_q == RunLast) begin
               state_d = StDone;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StFlush;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFlush;
         cnt_q   <= '0;
         sum_p_q <= '0;
         sum_n_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sum_p_q <= sum_p_d;
         sum_n_q <= sum_n_d;
      end
   end

   online_adder_serial_ctrl_sd_shift_reg #(
      .NDIG(NDIG)
   ) u_shift_a (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .shift (shift),
      .din_p (bus.a_p),
      .din_n (bus.a_n),
      .msd_p (ad_d1p),
      .msd_n (ad_d1n)
   );

   online_adder_serial_ctrl_sd_shift_reg #(
      .NDIG(NDIG)
   ) u_shift_b (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .shift (shift),
      .din_p (bus.b_p),
      .din_n (bus.b_n),
      .msd_p (ad_d2p),
      .msd_n (ad_d2n)
   );

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.sum_p     = sum_p_q;
   assign bus.sum_n     = sum_n_q;
   assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_online_adder_serial_ctrl.sv
// Bench for online_adder_serial_ctrl with NDIG=4, DELAY=2 and a behavioural radix-2 online
// adder (delay 2, unreset internal state) attached to the ad_* ports.
module tb_online_adder_serial_ctrl;

   localparam int unsigned NDIG  = 4;
   localparam int unsigned DELAY = 2;
   localparam int PhFlush = 0, PhIdle = 1, PhRun = 2, PhDone = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy, ad_d1p, ad_d1n, ad_d2p, ad_d2n, ad_qp, ad_qn;
   int   total = 0;
   int   bad = 0;
   bit   rand_bp = 1'b0;
   bit   or_fixed = 1'b1;

   online_adder_serial_ctrl_if #(.NDIG(NDIG)) bus ();

   online_adder_serial_ctrl #(
      .NDIG (NDIG),
      .DELAY(DELAY)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy),
      .ad_d1p(ad_d1p),
      .ad_d1n(ad_d1n),
      .ad_d2p(ad_d2p),
      .ad_d2n(ad_d2n),
      .ad_qp (ad_qp),
      .ad_qn (ad_qn)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sd_val(input logic [NDIG:0] p, input logic [NDIG:0] n);
      int v = 0;
      for (int i = 0; i <= int'(NDIG); i++) v += (int'(p[i]) - int'(n[i])) * (1 << i);
      return v;
   endfunction

   // ---------------- behavioural serial online adder (carry-free SD addition) ----------------
   // Digit-sum s_k = x_k + y_k is split as 2*t_k + w_k, the transfer choice looking at the next
   // less significant digit-sum; z_k = w_k + t_{k+1}. Output for position k needs s_{k+2}.
   int s_prev1 = 2;   // deliberately nonzero power-up state
   int s_prev2 = -1;
   int s_cur, z_cur;

   function automatic int xfer(input int s, input int slo);
      if (s >= 2) return 1;
      if (s <= -2) return -1;
      if (s == 1) return (slo >= 0) ? 1 : 0;
      if (s == -1) return (slo >= 0) ? 0 : -1;
      return 0;
   endfunction

   always_comb begin
      s_cur = int'(ad_d1p) - int'(ad_d1n) + int'(ad_d2p) - int'(ad_d2n);
      z_cur = (s_prev2 - 2 * xfer(s_prev2, s_prev1)) + xfer(s_prev1, s_cur);
      ad_qp = (z_cur > 0);
      ad_qn = (z_cur < 0);
   end

   always @(posedge clk) begin
      s_prev2 <= s_prev1;
      s_prev1 <= s_cur;
   end

   // ---------------- result consumer ----------------
   always begin
      @(posedge clk);
      #1;
      bus.out_ready = rand_bp ? ($urandom_range(3) != 0) : or_fixed;
   end

   // ---------------- reference model + per-cycle compare ----------------
   int              m_phase = PhFlush;
   int              m_k = 0;
   int              m_exp = 0;
   bit              m_first = 1'b0;
   logic [2*NDIG+1:0] m_held = '0;
   logic [NDIG-1:0] m_ap, m_an, m_bp, m_bn;

   always @(negedge clk) begin
      logic [3:0] ad_now, ad_exp;
      ad_now = {ad_d1p, ad_d1n, ad_d2p, ad_d2n};
      if (!rst_n) begin
         chk("rst_in_ready", bus.in_ready, 0);
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_busy", busy, 1);
         chk("rst_sum", {bus.sum_p, bus.sum_n}, 0);
         chk("rst_ad", ad_now, 0);
         m_phase = PhFlush;
         m_k     = 0;
      end else begin
         case (m_phase)
            PhFlush: begin
               chk("flush_in_ready", bus.in_ready, 0);
               chk("flush_busy", busy, 1);
               chk("flush_out_valid", bus.out_valid, 0);
               chk("flush_ad", ad_now, 0);
               chk("flush_sum", {bus.sum_p, bus.sum_n}, 0);
               m_k++;
               if (m_k == int'(DELAY)) m_phase = PhIdle;
            end
            PhIdle: begin
               chk("idle_in_ready", bus.in_ready, 1);
               chk("idle_busy", busy, 0);
               chk("idle_out_valid", bus.out_valid, 0);
               chk("idle_ad", ad_now, 0);
               if (bus.in_valid) begin
                  m_ap = bus.a_p;
                  m_an = bus.a_n;
                  m_bp = bus.b_p;
                  m_bn = bus.b_n;
                  m_exp = sd_val({1'b0, m_ap}, {1'b0, m_an}) + sd_val({1'b0, m_bp}, {1'b0, m_bn});
                  m_k = 0;
                  m_phase = PhRun;
               end
            end
            PhRun: begin
               if (m_k < int'(NDIG))
                  ad_exp = {m_ap[NDIG-1-m_k], m_an[NDIG-1-m_k], m_bp[NDIG-1-m_k], m_bn[NDIG-1-m_k]};
               else
                  ad_exp = 4'b0000;
               chk("run_ad", ad_now, ad_exp);
               chk("run_in_ready", bus.in_ready, 0);
               chk("run_busy", busy, 1);
               chk("run_out_valid", bus.out_valid, 0);
               m_k++;
               if (m_k == int'(NDIG + DELAY)) begin
                  m_phase = PhDone;
                  m_first = 1'b1;
               end
            end
            default: begin
               chk("done_out_valid", bus.out_valid, 1);
               chk("done_in_ready", bus.in_ready, 0);
               chk("done_busy", busy, 1);
               chk("done_ad", ad_now, 0);
               chk("done_value", sd_val(bus.sum_p, bus.sum_n), m_exp);
               if (!m_first) chk("done_stable", {bus.sum_p, bus.sum_n}, m_held);
               m_held  = {bus.sum_p, bus.sum_n};
               m_first = 1'b0;
               if (bus.out_ready) m_phase = PhIdle;
            end
         endcase
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_flush(input string name);
      int n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready) break;
         n++;
      end
      chk(name, n, DELAY);
   endtask

   task automatic do_op(input logic [NDIG-1:0] ap, input logic [NDIG-1:0] an,
                        input logic [NDIG-1:0] bp, input logic [NDIG-1:0] bn, output int res);
      int lat = 0;
      bit ok = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a_p = ap;
      bus.a_n = an;
      bus.b_p = bp;
      bus.b_n = bn;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("accept_seen", ok, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         lat++;
         if (bus.out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("out_valid_seen", ok, 1);
      chk("latency", lat, NDIG + DELAY + 1);
      res = sd_val(bus.sum_p, bus.sum_n);
   endtask

   initial begin
      int res, held, exp_v;
      logic [NDIG-1:0] rap, ran, rbp, rbn;
      bus.in_valid = 1'b0;
      bus.a_p = '0;
      bus.a_n = '0;
      bus.b_p = '0;
      bus.b_n = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_flush("flush_len");

      do_op(4'b0101, 4'b0000, 4'b0011, 4'b0000, res);
      chk("p5_plus_p3", res, 8);
      do_op(4'b0000, 4'b0111, 4'b0010, 4'b0000, res);
      chk("m7_plus_p2", res, -5);
      do_op(4'b0000, 4'b0000, 4'b0000, 4'b0000, res);
      chk("zero_after", res, 0);
      do_op(4'b1111, 4'b0000, 4'b1111, 4'b0000, res);
      chk("p15_plus_p15", res, 30);
      chk("p30_msd", bus.sum_p[NDIG], 1);
      do_op(4'b0000, 4'b1111, 4'b0000, 4'b1111, res);
      chk("m15_plus_m15", res, -30);
      chk("m30_msd", bus.sum_n[NDIG], 1);

      // Backpressure: result must hold while a new operand is offered and refused.
      or_fixed = 1'b0;
      do_op(4'b0110, 4'b0000, 4'b0000, 4'b0001, res);
      chk("p6_plus_m1", res, 5);
      held = res;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a_p = 4'b1010;
      bus.b_n = 4'b0101;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_out_valid", bus.out_valid, 1);
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_hold", sd_val(bus.sum_p, bus.sum_n), held);
      end
      or_fixed = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a_p = '0;
      bus.b_n = '0;
      repeat (4) @(negedge clk);

      // Reset in the middle of a run: partial result discarded, flush repeated.
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a_p = 4'b0101;
      bus.b_p = 4'b0011;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.in_ready) break;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", bus.in_ready, 0);
      chk("mid_rst_out_valid", bus.out_valid, 0);
      chk("mid_rst_busy", busy, 1);
      chk("mid_rst_sum", {bus.sum_p, bus.sum_n}, 0);
      chk("mid_rst_ad", {ad_d1p, ad_d1n, ad_d2p, ad_d2n}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      bus.a_p = '0;
      bus.b_p = '0;
      wait_flush("flush_len_again");
      do_op(4'b0001, 4'b0000, 4'b0001, 4'b0000, res);
      chk("p1_plus_p1", res, 2);

      // Randomized operands with a randomly stalling consumer.
      rand_bp = 1'b1;
      for (int i = 0; i < 30; i++) begin
         rap = NDIG'($urandom);
         ran = NDIG'($urandom);
         rbp = NDIG'($urandom);
         rbn = NDIG'($urandom);
         exp_v = sd_val({1'b0, rap}, {1'b0, ran}) + sd_val({1'b0, rbp}, {1'b0, rbn});
         do_op(rap, ran, rbp, rbn, res);
         chk("rand_value", res, exp_v);
      end
      rand_bp = 1'b0;
      repeat (6) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
